// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - two-player game sequencer: menu, countdown, gameplay health tracking, game-over hold
module game_state_controller #(
  parameter int MAX_HEALTH    = 3,
  parameter int SEC_TICKS     = 60,
  parameter int HIT_COOLDOWN  = 30,
  parameter int GAMEOVER_HOLD = 120
) (
  input  logic       clk_game,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [2:0] current_game_state,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic [1:0] countdown_value,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int STEP_W = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam int COOL_W = (HIT_COOLDOWN > 0) ? $clog2(HIT_COOLDOWN + 1) : 1;
  localparam int HOLD_W = (GAMEOVER_HOLD > 0) ? $clog2(GAMEOVER_HOLD + 1) : 1;

  localparam logic [2:0]        HEALTH_FULL = 3'(MAX_HEALTH);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(SEC_TICKS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);
  localparam logic [COOL_W-1:0] COOL_LOAD   = COOL_W'(HIT_COOLDOWN);
  localparam logic [COOL_W-1:0] COOL_ONE    = COOL_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(GAMEOVER_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  typedef enum logic [2:0] {
    MENU      = 3'b000,
    COUNTDOWN = 3'b001,
    GAMEPLAY  = 3'b010,
    GAME_OVER = 3'b011
  } state_t;

  state_t            state, state_next;
  logic [STEP_W-1:0] step, step_next;
  logic [COOL_W-1:0] p1_cool, p1_cool_next, p2_cool, p2_cool_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic [2:0]        p1_health_next, p2_health_next;
  logic [1:0]        countdown_next, winner_next;
  logic              game_over_next;

  // Hit qualification; only consumed while in GAMEPLAY.
  logic       p1_apply, p2_apply;
  logic [2:0] p1_after, p2_after;
  assign p1_apply = p1_hit && (p1_health != 3'd0) && (p1_cool == '0);
  assign p2_apply = p2_hit && (p2_health != 3'd0) && (p2_cool == '0);
  assign p1_after = p1_apply ? p1_health - 3'd1 : p1_health;
  assign p2_after = p2_apply ? p2_health - 3'd1 : p2_health;

  assign current_game_state = state;

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      state           <= MENU;
      step            <= '0;
      p1_cool         <= '0;
      p2_cool         <= '0;
      hold            <= '0;
      p1_health       <= HEALTH_FULL;
      p2_health       <= HEALTH_FULL;
      countdown_value <= 2'd0;
      game_over       <= 1'b0;
      winner          <= 2'b00;
    end else begin
      state           <= state_next;
      step            <= step_next;
      p1_cool         <= p1_cool_next;
      p2_cool         <= p2_cool_next;
      hold            <= hold_next;
      p1_health       <= p1_health_next;
      p2_health       <= p2_health_next;
      countdown_value <= countdown_next;
      game_over       <= game_over_next;
      winner          <= winner_next;
    end
  end

  always_comb begin
    state_next     = state;
    step_next      = step;
    p1_cool_next   = p1_cool;
    p2_cool_next   = p2_cool;
    hold_next      = hold;
    p1_health_next = p1_health;
    p2_health_next = p2_health;
    countdown_next = countdown_value;
    game_over_next = game_over;
    winner_next    = winner;

    case (state)
      MENU: begin
        p1_health_next = HEALTH_FULL;
        p2_health_next = HEALTH_FULL;
        winner_next    = 2'b00;
        game_over_next = 1'b0;
        countdown_next = 2'd0;
        step_next      = '0;
        p1_cool_next   = '0;
        p2_cool_next   = '0;
        hold_next      = '0;
        if (start_btn) begin
          state_next     = COUNTDOWN;
          countdown_next = 2'd3;
        end
      end

      COUNTDOWN: begin
        if (step == STEP_LAST) begin
          step_next = '0;
          if (countdown_value == 2'd1) begin
            state_next     = GAMEPLAY;
            countdown_next = 2'd0;
            p1_cool_next   = '0;
            p2_cool_next   = '0;
          end else begin
            countdown_next = countdown_value - 2'd1;
          end
        end else begin
          step_next = step + STEP_ONE;
        end
      end

      GAMEPLAY: begin
        p1_cool_next   = p1_apply ? COOL_LOAD : ((p1_cool != '0) ? p1_cool - COOL_ONE : '0);
        p2_cool_next   = p2_apply ? COOL_LOAD : ((p2_cool != '0) ? p2_cool - COOL_ONE : '0);
        p1_health_next = p1_after;
        p2_health_next = p2_after;
        if ((p1_after == 3'd0) || (p2_after == 3'd0)) begin
          state_next     = GAME_OVER;
          game_over_next = 1'b1;
          // bit1 flags P1 down (P2 wins), bit0 flags P2 down (P1 wins); both set = draw
          winner_next    = {p1_after == 3'd0, p2_after == 3'd0};
          hold_next      = '0;
        end
      end

      GAME_OVER: begin
        if (hold != HOLD_MAX) begin
          hold_next = hold + HOLD_ONE;
        end else if (start_btn) begin
          state_next     = MENU;
          p1_health_next = HEALTH_FULL;
          p2_health_next = HEALTH_FULL;
          winner_next    = 2'b00;
          game_over_next = 1'b0;
          hold_next      = '0;
        end
      end

      default: begin
        state_next     = MENU;
        p1_health_next = HEALTH_FULL;
        p2_health_next = HEALTH_FULL;
        countdown_next = 2'd0;
        game_over_next = 1'b0;
        winner_next    = 2'b00;
        step_next      = '0;
        p1_cool_next   = '0;
        p2_cool_next   = '0;
        hold_next      = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - scoreboard bench for game_state_controller
module tb_game_state_controller;

  localparam logic [2:0] S_MENU = 3'd0, S_CD = 3'd1, S_GP = 3'd2, S_GO = 3'd3;

  logic       clk_game = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0, p1_hit = 1'b0, p2_hit = 1'b0;
  logic [2:0] current_game_state, p1_health, p2_health;
  logic [1:0] countdown_value, winner;
  logic       game_over;

  game_state_controller #(
    .MAX_HEALTH(3), .SEC_TICKS(4), .HIT_COOLDOWN(5), .GAMEOVER_HOLD(10)
  ) dut (
    .clk_game(clk_game), .reset(reset), .start_btn(start_btn),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .current_game_state(current_game_state),
    .p1_health(p1_health), .p2_health(p2_health),
    .countdown_value(countdown_value), .game_over(game_over), .winner(winner)
  );

  always #5 clk_game = ~clk_game;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [2:0] h1;
    logic [2:0] h2;
    logic [1:0] cv;
    logic       go;
    logic [1:0] win;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check_eq({e.tag, ".state"}, 8'(current_game_state), 8'(e.st));
    check_eq({e.tag, ".p1"},    8'(p1_health),          8'(e.h1));
    check_eq({e.tag, ".p2"},    8'(p2_health),          8'(e.h2));
    check_eq({e.tag, ".cd"},    8'(countdown_value),    8'(e.cv));
    check_eq({e.tag, ".go"},    8'(game_over),          8'(e.go));
    check_eq({e.tag, ".win"},   8'(winner),             8'(e.win));
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e = '{tag, S_MENU, 3'd3, 3'd3, 2'd0, 1'b0, 2'd0};
    check_outputs(e);
  endtask

  // Scoreboard consumer: one expectation per clock edge it was pushed for.
  always @(posedge clk_game) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_outputs(e);
    end
  end

  task automatic step(input logic s, input logic a, input logic b,
                      input logic [2:0] st, input logic [2:0] h1, input logic [2:0] h2,
                      input logic [1:0] cv, input logic go, input logic [1:0] win,
                      input string tag);
    exp_t e;
    @(negedge clk_game);
    start_btn = s;
    p1_hit    = a;
    p2_hit    = b;
    e = '{tag, st, h1, h2, cv, go, win};
    sb.push_back(e);
    @(posedge clk_game);
    #2;
    start_btn = 1'b0;
    p1_hit    = 1'b0;
    p2_hit    = 1'b0;
  endtask

  task automatic idle(input int n, input logic [2:0] st, input logic [2:0] h1, input logic [2:0] h2,
                      input logic go, input logic [1:0] win, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, st, h1, h2, 2'd0, go, win, tag);
  endtask

  // Start pulse then 12 countdown edges; stray start/hits are injected and must be ignored.
  task automatic run_countdown(input string tag);
    step(1'b1, 1'b0, 1'b0, S_CD, 3'd3, 3'd3, 2'd3, 1'b0, 2'd0, {tag, "_start"});
    for (int k = 1; k < 12; k++)
      step(k == 2, (k == 5) || (k == 9), k == 9, S_CD, 3'd3, 3'd3, 2'(3 - k / 4), 1'b0, 2'd0,
           $sformatf("%s_k%0d", tag, k));
    step(1'b0, 1'b0, 1'b0, S_GP, 3'd3, 3'd3, 2'd0, 1'b0, 2'd0, {tag, "_gp"});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk_game);
    check_reset("reset");
    reset = 1'b0;

    step(1'b0, 1'b1, 1'b0, S_MENU, 3'd3, 3'd3, 2'd0, 1'b0, 2'd0, "menu_p1");
    step(1'b0, 1'b1, 1'b1, S_MENU, 3'd3, 3'd3, 2'd0, 1'b0, 2'd0, "menu_both");

    // Cooldown, simultaneous lethal hit and draw, then exact hold boundary.
    run_countdown("cd1");
    step(1'b0, 1'b1, 1'b1, S_GP, 3'd2, 3'd2, 2'd0, 1'b0, 2'd0, "hit_both");
    step(1'b1, 1'b0, 1'b0, S_GP, 3'd2, 3'd2, 2'd0, 1'b0, 2'd0, "gp_start_ign");
    idle(1, S_GP, 3'd2, 3'd2, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b1, 1'b0, S_GP, 3'd2, 3'd2, 2'd0, 1'b0, 2'd0, "p1_cool_drop");
    idle(2, S_GP, 3'd2, 3'd2, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b1, 1'b1, S_GP, 3'd1, 3'd1, 2'd0, 1'b0, 2'd0, "hit_after_cool");
    idle(5, S_GP, 3'd1, 3'd1, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b1, 1'b1, S_GO, 3'd0, 3'd0, 2'd0, 1'b1, 2'd3, "draw");
    step(1'b0, 1'b1, 1'b1, S_GO, 3'd0, 3'd0, 2'd0, 1'b1, 2'd3, "go_hits_ign");
    step(1'b1, 1'b0, 1'b0, S_GO, 3'd0, 3'd0, 2'd0, 1'b1, 2'd3, "go_start_early");
    idle(8, S_GO, 3'd0, 3'd0, 1'b1, 2'd3, "go_hold");
    step(1'b1, 1'b0, 1'b0, S_MENU, 3'd3, 3'd3, 2'd0, 1'b0, 2'd0, "go_start_hold10");

    // P2 lethal: P1 wins; start at hold 4 and 9 ignored, accepted later.
    run_countdown("cd2");
    step(1'b0, 1'b0, 1'b1, S_GP, 3'd3, 3'd2, 2'd0, 1'b0, 2'd0, "p2_hit");
    idle(4, S_GP, 3'd3, 3'd2, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b0, 1'b1, S_GP, 3'd3, 3'd2, 2'd0, 1'b0, 2'd0, "p2_cool1_drop");
    step(1'b0, 1'b0, 1'b1, S_GP, 3'd3, 3'd1, 2'd0, 1'b0, 2'd0, "p2_cool0_hit");
    idle(5, S_GP, 3'd3, 3'd1, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b0, 1'b1, S_GO, 3'd3, 3'd0, 2'd0, 1'b1, 2'd1, "p1_wins");
    idle(4, S_GO, 3'd3, 3'd0, 1'b1, 2'd1, "go_hold");
    step(1'b1, 1'b0, 1'b0, S_GO, 3'd3, 3'd0, 2'd0, 1'b1, 2'd1, "hold4_ign");
    idle(4, S_GO, 3'd3, 3'd0, 1'b1, 2'd1, "go_hold");
    step(1'b1, 1'b0, 1'b0, S_GO, 3'd3, 3'd0, 2'd0, 1'b1, 2'd1, "hold9_ign");
    idle(2, S_GO, 3'd3, 3'd0, 1'b1, 2'd1, "go_hold");
    step(1'b1, 1'b0, 1'b0, S_MENU, 3'd3, 3'd3, 2'd0, 1'b0, 2'd0, "restart");

    // Reset mid-gameplay with cooldown active, then a clean game where P2 wins.
    run_countdown("cd3");
    step(1'b0, 1'b1, 1'b1, S_GP, 3'd2, 3'd2, 2'd0, 1'b0, 2'd0, "pre_hit");
    idle(5, S_GP, 3'd2, 3'd2, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b0, 1'b1, S_GP, 3'd2, 3'd1, 2'd0, 1'b0, 2'd0, "pre_rst");
    idle(1, S_GP, 3'd2, 3'd1, 1'b0, 2'd0, "gp_idle");
    @(negedge clk_game);
    reset = 1'b1;
    #1;
    check_reset("mid_reset");
    @(negedge clk_game);
    reset = 1'b0;
    run_countdown("cd4");
    step(1'b0, 1'b1, 1'b1, S_GP, 3'd2, 3'd2, 2'd0, 1'b0, 2'd0, "post_rst_hit");
    idle(5, S_GP, 3'd2, 3'd2, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b1, 1'b0, S_GP, 3'd1, 3'd2, 2'd0, 1'b0, 2'd0, "p1_hit2");
    idle(5, S_GP, 3'd1, 3'd2, 1'b0, 2'd0, "gp_idle");
    step(1'b0, 1'b1, 1'b0, S_GO, 3'd0, 3'd2, 2'd0, 1'b1, 2'd2, "p2_wins");

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk_game);
    #2;
    check_eq("drain", 8'(sb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
